// File: rtl/gray_step_seq_if.sv
// Command/status bundle for gray_step_seq.
// Defining GRAY_STEP_SEQ_PAUSE_EN adds the pause input to the bundle.
interface gray_step_seq_if #(
  parameter int DIVWIDTH  = 8,
  parameter int STEPWIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [STEPWIDTH-1:0] cmd_steps;
  logic [DIVWIDTH-1:0]  cmd_div;
  logic                 abort;
`ifdef GRAY_STEP_SEQ_PAUSE_EN
  logic                 pause;
`endif
  logic                 step_en;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [STEPWIDTH-1:0] remaining;
  logic                 wrap;

`ifdef GRAY_STEP_SEQ_PAUSE_EN
  modport master (
    output cmd_valid, cmd_steps, cmd_div, abort, pause,
    input  cmd_ready, step_en, busy, done, aborted, remaining, wrap
  );
  modport slave (
    input  cmd_valid, cmd_steps, cmd_div, abort, pause,
    output cmd_ready, step_en, busy, done, aborted, remaining, wrap
  );
`else
  modport master (
    output cmd_valid, cmd_steps, cmd_div, abort,
    input  cmd_ready, step_en, busy, done, aborted, remaining, wrap
  );
  modport slave (
    input  cmd_valid, cmd_steps, cmd_div, abort,
    output cmd_ready, step_en, busy, done, aborted, remaining, wrap
  );
`endif
endinterface

// File: rtl/gray_step_seq.sv
// Issues a programmed number of evenly spaced enable pulses to an external Gray counter.
// Optional pause support is compiled in when GRAY_STEP_SEQ_PAUSE_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | prescaler counting, step_en issued each div+1 cycles
//   PAUSE | prescaler and remaining frozen while pause is high
//   DONE  | one-cycle exit; done (and aborted) register on leaving
module gray_step_seq #(
  parameter int GRAYWIDTH = 3,
  parameter int DIVWIDTH  = 8,
  parameter int STEPWIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  gray_step_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [DIVWIDTH-1:0]  div_q;
  logic [DIVWIDTH-1:0]  prescaler;
  logic [STEPWIDTH-1:0] remaining_q;
  logic [GRAYWIDTH-1:0] mirror;
  logic                 abort_flag;
  logic                 step_en_q;
  logic                 wrap_q;
  logic                 done_q;
  logic                 aborted_q;

  logic load;
  logic fire;
  logic pre_inc;
  logic abort_set;
  logic finish;
  logic pause_in;

`ifdef GRAY_STEP_SEQ_PAUSE_EN
  assign pause_in = bus.pause;
`else
  assign pause_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort outranks pause, and pause outranks a step that would fire this cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fire      = 1'b0;
    pre_inc   = 1'b0;
    abort_set = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          load      = 1'b1;
          state_nxt = (bus.cmd_steps != '0) ? RUN : DONE;
        end
      end
      RUN, PAUSE: begin
        if (bus.abort) begin
          abort_set = 1'b1;
          state_nxt = DONE;
        end else if (pause_in) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
          if (prescaler == div_q) begin
            fire = 1'b1;
            if (remaining_q == STEPWIDTH'(1)) state_nxt = DONE;
          end else begin
            pre_inc = 1'b1;
          end
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      prescaler   <= '0;
      remaining_q <= '0;
      mirror      <= '0;
      abort_flag  <= 1'b0;
      step_en_q   <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      step_en_q <= fire;
      wrap_q    <= fire && (mirror == '1);
      done_q    <= finish;
      aborted_q <= finish && abort_flag;
      if (load) begin
        div_q       <= bus.cmd_div;
        remaining_q <= bus.cmd_steps;
        prescaler   <= '0;
        abort_flag  <= 1'b0;
      end
      if (fire) begin
        prescaler   <= '0;
        remaining_q <= remaining_q - STEPWIDTH'(1);
        mirror      <= mirror + GRAYWIDTH'(1);
      end
      if (pre_inc) prescaler <= prescaler + DIVWIDTH'(1);
      if (abort_set) abort_flag <= 1'b1;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.step_en   = step_en_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_gray_step_seq.sv
// Directed self-checking bench for gray_step_seq; cycle k means the k-th rising edge after the accepting edge.
module tb_gray_step_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   total_steps;

  gray_step_seq_if #(.DIVWIDTH(8), .STEPWIDTH(8)) bus();

  gray_step_seq #(.GRAYWIDTH(3), .DIVWIDTH(8), .STEPWIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_div   = '0;
    bus.abort     = 1'b0;
`ifdef GRAY_STEP_SEQ_PAUSE_EN
    bus.pause     = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.step_en !== 1'b0 || bus.done !== 1'b0 ||
        bus.aborted !== 1'b0 || bus.wrap !== 1'b0 || bus.remaining !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values ready=%b busy=%b step=%b done=%b ab=%b wrap=%b rem=%0d expected 1,0,0,0,0,0,0",
               bus.cmd_ready, bus.busy, bus.step_en, bus.done, bus.aborted, bus.wrap, bus.remaining);
    end
    rst_n = 1'b1;
    bus.abort = 1'b1;
    tick();
    tick();
    bus.abort = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.aborted !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_in_idle busy=%b aborted=%b done=%b expected 0,0,0", bus.busy, bus.aborted, bus.done);
    end
    total_steps = 0;
  endtask

  task automatic test_basic();
    bit exp_step, exp_wrap, exp_done;
    bus.cmd_steps = 8'd5;
    bus.cmd_div   = 8'd2;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.remaining !== 8'd5 || bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_accept busy=%b rem=%0d ready=%b expected 1,5,0", bus.busy, bus.remaining, bus.cmd_ready);
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp_step = (k % 3 == 0) && (k <= 15);
      exp_wrap = exp_step && (total_steps % 8 == 7);
      if (exp_step) total_steps++;
      exp_done = (k == 16);
      vectors++;
      if (bus.step_en !== exp_step || bus.wrap !== exp_wrap || bus.done !== exp_done || bus.aborted !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_cycle%0d step=%b wrap=%b done=%b ab=%b expected %b,%b,%b,0",
                 k, bus.step_en, bus.wrap, bus.done, bus.aborted, exp_step, exp_wrap, exp_done);
      end
    end
    vectors++;
    if (bus.remaining !== 8'd0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end rem=%0d ready=%b busy=%b expected 0,1,0", bus.remaining, bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_zero_steps();
    bus.cmd_steps = 8'd0;
    bus.cmd_div   = 8'd7;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.step_en !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_cycle0 busy=%b ready=%b step=%b done=%b expected 1,0,0,0",
               bus.busy, bus.cmd_ready, bus.step_en, bus.done);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.aborted !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.step_en !== 1'b0 ||
        bus.remaining !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_cycle1 done=%b ab=%b ready=%b step=%b rem=%0d expected 1,0,1,0,0",
               bus.done, bus.aborted, bus.cmd_ready, bus.step_en, bus.remaining);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.step_en !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_cycle2 done=%b busy=%b step=%b expected 0,0,0", bus.done, bus.busy, bus.step_en);
    end
  endtask

  task automatic test_abort();
    bit exp_step, exp_wrap, exp_done;
    bus.cmd_steps = 8'd6;
    bus.cmd_div   = 8'd1;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      bus.abort = (k == 6) || (k == 9);
      tick();
      exp_step = (k == 2) || (k == 4);
      exp_wrap = exp_step && (total_steps % 8 == 7);
      if (exp_step) total_steps++;
      exp_done = (k == 7);
      vectors++;
      if (bus.step_en !== exp_step || bus.wrap !== exp_wrap || bus.done !== exp_done || bus.aborted !== exp_done) begin
        miscompares++;
        $display("FAIL abort_cycle%0d step=%b wrap=%b done=%b ab=%b expected %b,%b,%b,%b",
                 k, bus.step_en, bus.wrap, bus.done, bus.aborted, exp_step, exp_wrap, exp_done, exp_done);
      end
      if (k == 7 || k == 11) begin
        vectors++;
        if (bus.remaining !== 8'd4) begin
          miscompares++;
          $display("FAIL abort_remaining cycle%0d rem=%0d expected 4", k, bus.remaining);
        end
      end
    end
    bus.abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit exp_step, exp_wrap, exp_done, exp_busy;
    logic [7:0] exp_rem;
    bus.cmd_steps = 8'd2;
    bus.cmd_div   = 8'd1;
    bus.cmd_valid = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      bus.cmd_steps = (k >= 1 && k <= 5) ? 8'd9 : 8'd2;
      bus.cmd_valid = (k <= 6);
      tick();
      exp_step = (k == 2) || (k == 4) || (k == 8) || (k == 10);
      exp_wrap = exp_step && (total_steps % 8 == 7);
      if (exp_step) total_steps++;
      exp_done = (k == 5) || (k == 11);
      exp_busy = !((k == 5) || (k >= 11));
      if (k < 2)       exp_rem = 8'd2;
      else if (k < 4)  exp_rem = 8'd1;
      else if (k < 6)  exp_rem = 8'd0;
      else if (k < 8)  exp_rem = 8'd2;
      else if (k < 10) exp_rem = 8'd1;
      else             exp_rem = 8'd0;
      vectors++;
      if (bus.step_en !== exp_step || bus.wrap !== exp_wrap || bus.done !== exp_done ||
          bus.busy !== exp_busy || bus.remaining !== exp_rem) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d step=%b wrap=%b done=%b busy=%b rem=%0d expected %b,%b,%b,%b,%0d",
                 k, bus.step_en, bus.wrap, bus.done, bus.busy, bus.remaining,
                 exp_step, exp_wrap, exp_done, exp_busy, exp_rem);
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_wrap();
    bit exp_step, exp_wrap, exp_done;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total_steps = 0;
    bus.cmd_steps = 8'd10;
    bus.cmd_div   = 8'd0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_step = (k <= 10);
      exp_wrap = (k == 8);
      if (exp_step) total_steps++;
      exp_done = (k == 11);
      vectors++;
      if (bus.step_en !== exp_step || bus.wrap !== exp_wrap || bus.done !== exp_done) begin
        miscompares++;
        $display("FAIL wrap_cycle%0d step=%b wrap=%b done=%b expected %b,%b,%b",
                 k, bus.step_en, bus.wrap, bus.done, exp_step, exp_wrap, exp_done);
      end
    end
  endtask

`ifdef GRAY_STEP_SEQ_PAUSE_EN
  task automatic test_pause();
    bit exp_step, exp_wrap, exp_done;
    bus.cmd_steps = 8'd3;
    bus.cmd_div   = 8'd3;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      bus.pause = (k >= 5) && (k <= 14);
      tick();
      exp_step = (k == 4) || (k == 18) || (k == 22);
      exp_wrap = exp_step && (total_steps % 8 == 7);
      if (exp_step) total_steps++;
      exp_done = (k == 23);
      vectors++;
      if (bus.step_en !== exp_step || bus.wrap !== exp_wrap || bus.done !== exp_done || bus.aborted !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_cycle%0d step=%b wrap=%b done=%b ab=%b expected %b,%b,%b,0",
                 k, bus.step_en, bus.wrap, bus.done, bus.aborted, exp_step, exp_wrap, exp_done);
      end
      if (k == 10) begin
        vectors++;
        if (bus.remaining !== 8'd2 || bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL pause_frozen rem=%0d busy=%b expected 2,1", bus.remaining, bus.busy);
        end
      end
    end
    bus.pause = 1'b0;
  endtask
`endif

  task automatic test_reset_midrun();
    bus.cmd_steps = 8'd4;
    bus.cmd_div   = 8'd0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    vectors++;
    if (bus.step_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_step step=%b expected 1", bus.step_en);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.step_en !== 1'b0 || bus.busy !== 1'b0 || bus.remaining !== 8'd0 || bus.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_async step=%b busy=%b rem=%0d wrap=%b expected 0,0,0,0",
               bus.step_en, bus.busy, bus.remaining, bus.wrap);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.step_en !== 1'b0) begin
        miscompares++;
        $display("FAIL midrun_held%0d done=%b step=%b expected 0,0", k, bus.done, bus.step_en);
      end
    end
    rst_n = 1'b1;
    total_steps = 0;
    tick();
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.step_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_release ready=%b done=%b step=%b expected 1,0,0", bus.cmd_ready, bus.done, bus.step_en);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    total_steps = 0;
    rst_n       = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_zero_steps();
    test_abort();
    test_back_to_back();
    test_wrap();
`ifdef GRAY_STEP_SEQ_PAUSE_EN
    test_pause();
`endif
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
